uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter forming the sending end of the team's one-wire UART link: accepts one byte per valid/ready handshake and shifts it out on `serial` as start bit, eight data bits LSB-first, optional parity, and stop bit(s). It drives the command link that feeds the display receiver. Upper nibble carries the command: 0001 clear, 0010 load, 0100 show. Lower nibble carries the 4-bit value. The block does not interpret the byte.

## Interface
- `CLKS_PER_BIT`, default 2: clock cycles per serial bit; legal range 1..65535.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled only on an accepting edge.
- `tx_valid`  in  1  producer offers `tx_data`.
- `tx_ready`  out  1  block can accept; high only in IDLE.
- `serial`  out  1  line output; idle/mark level is 1.
- `busy`  out  1  frame in progress (the inverse of `tx_ready`).
- `tx_done`  out  1  one-cycle pulse on the final cycle of the last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (only with `UART_TX_PARITY_EN`), STOP.
- **IDLE**
  - `serial`=1, `tx_ready`=1.
  - If `tx_valid` is high on a rising edge, latch `tx_data` into the shift register, clear the baud counter and bit index, and go to START.
- **START**: `serial`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `serial`=shift_reg[0] for `CLKS_PER_BIT` cycles per bit, then shift right.
  - After bit index 7, go to PARITY if enabled, otherwise to STOP.
- **PARITY**: `serial`=even parity (XOR of the 8 latched bits) for `CLKS_PER_BIT` cycles.
- **STOP**
  - `serial`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
  - `tx_done`=1 on the last of those cycles, then return to IDLE.
- Baud counter width is $clog2(`CLKS_PER_BIT`+1). It counts 0..`CLKS_PER_BIT`-1 and wraps on bit advance.
- Bit index is 3 bits and saturates logic at 7; no wrap into a 9th data bit.
- `tx_valid` and `tx_data` are ignored outside IDLE. A held `tx_valid` is not queued. The producer must re-present after `tx_ready` rises.
- `tx_data` changes after acceptance do not affect the frame in flight.

## Timing
- Reset values: `serial`=1, `tx_ready`=1, `busy`=0, `tx_done`=0. The FSM goes to IDLE and counters clear.
- Reset assertion mid-frame forces `serial`=1 immediately, without waiting for the clock. The frame is abandoned; no `tx_done` is produced.
- All outputs are registered, with no combinational path from `tx_valid` to any output.
- Accept edge is E. `serial` goes low in the cycle after E.
- Frame length after acceptance is (10 + P + `STOP_BITS` − 1)×`CLKS_PER_BIT` cycles, where P=1 with parity and 0 without.
- `tx_ready` rises the cycle after `tx_done`.
- Back-to-back throughput: one frame per frame length + 1 cycles, because a new accept is possible on the first IDLE edge.
- `CLKS_PER_BIT`=1: each bit lasts exactly one cycle; behaviour is otherwise unchanged.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is compiled in and one even-parity bit is inserted between data bit 7 and the stop bit.
  - Frame is 11 bits plus any extra stop bit.
- Not defined:
  - PARITY state and parity logic are absent and the frame is 10 bits (with `STOP_BITS`=1).
  - The default build is for the existing receiver, which expects no parity.

## Test plan
- Reset, then idle 20 cycles -> `serial`=1, `tx_ready`=1, `busy`=0, `tx_done`=0 throughout.
- `CLKS_PER_BIT`=2, send 0x24 -> after E, `serial` (2 cycles each) is 0 | 0,0,1,0,0,1,0,0 | 1. `tx_done` is high on cycle 20 after E, and `tx_ready` is high on cycle 21.
- Send 0x1F, hold `tx_valid` high with `tx_data`=0x4A during the frame -> only 0x1F is transmitted. 0x4A is accepted on the first IDLE edge and both frames are bit-exact.
- Assert `reset_n`=0 at bit index 3 of 0xA5 -> `serial`=1 in the same cycle, `busy`=0, no `tx_done`. After release, 0x42 transmits cleanly.
- `UART_TX_PARITY_EN`, send 0x07 then 0x24 -> the parity bit is 1 for 0x07 and 0 for 0x24. Each frame is 22 cycles at `CLKS_PER_BIT`=2.
- `STOP_BITS`=2, `CLKS_PER_BIT`=3, send 0xFF -> the line stays high for 24+6 cycles after the start bit. `tx_done` is on the 33rd cycle after E.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the uart_tx serial transmitter.
`default_nettype none

interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// uart_tx: start bit, 8 data bits LSB-first, optional even parity, 1..2 stop bits.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 2,
  parameter int STOP_BITS    = 1
) (
  input  wire logic  clock,
  input  wire logic  reset_n,
  uart_tx_if.slave   tx_if,
  output logic       serial,
  output logic       busy,
  output logic       tx_done
);

  localparam int             CW          = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  c_LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic           c_LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_stop, w_stop_nxt;
  logic          r_serial, w_serial_nxt;
  logic          r_ready, w_ready_nxt;
  logic          r_busy;
  logic          r_done, w_done_nxt;
  logic          w_bit_end;
  logic          w_accept;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  assign w_bit_end = (r_cnt == c_LAST_CNT);
  assign w_accept  = (r_state == S_IDLE) && tx_if.tx_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_stop   <= 1'b0;
      r_serial <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_stop   <= w_stop_nxt;
      r_serial <= w_serial_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= ~w_ready_nxt;
      r_done   <= w_done_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^tx_if.tx_data;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_stop_nxt  = r_stop;

    case (r_state)
      S_IDLE: begin
        if (tx_if.tx_valid) begin
          w_shift_nxt = tx_if.tx_data;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          // Index stops at 7 so the frame can never grow a ninth data bit.
          if (r_idx == 3'd7) begin
            w_stop_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_stop_nxt  = 1'b0;
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_stop == c_LAST_STOP) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in registers.
  always_comb begin
    w_serial_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_serial_nxt = r_par;
`endif
      default:  w_serial_nxt = 1'b1;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_done_nxt  = (w_state_nxt == S_STOP) && (w_cnt_nxt == c_LAST_CNT) &&
                  (w_stop_nxt == c_LAST_STOP);
  end

  assign tx_if.tx_ready = r_ready;
  assign serial         = r_serial;
  assign busy           = r_busy;
  assign tx_done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (2/1, 3/2 and 1/1 clocks-per-bit/stop-bits).
`default_nettype none

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clock;
  logic reset_n;
  logic ser0, busy0, done0;
  logic ser1, busy1, done1;
  logic ser2, busy2, done2;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();

  uart_tx #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .tx_if(if0),
    .serial(ser0), .busy(busy0), .tx_done(done0));
  uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .tx_if(if1),
    .serial(ser1), .busy(busy1), .tx_done(done1));
  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .tx_if(if2),
    .serial(ser2), .busy(busy2), .tx_done(done2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int cpb_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction

  function automatic int stops_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  // Line level at cycle k (1 = first cycle after the accepting edge).
  function automatic logic exp_line(input logic [7:0] b, input int k, input int cpb);
    int slot;
    slot = (k - 1) / cpb;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR == 1 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic drive(input int d, input logic v, input logic [7:0] x);
    case (d)
      0:       begin if0.tx_valid = v; if0.tx_data = x; end
      1:       begin if1.tx_valid = v; if1.tx_data = x; end
      default: begin if2.tx_valid = v; if2.tx_data = x; end
    endcase
  endtask

  // {serial, tx_done, tx_ready, busy}
  task automatic sample(input int d, output logic [3:0] v);
    case (d)
      0:       v = {ser0, done0, if0.tx_ready, busy0};
      1:       v = {ser1, done1, if1.tx_ready, busy1};
      default: v = {ser2, done2, if2.tx_ready, busy2};
    endcase
  endtask

  task automatic offer(input int d, input logic [7:0] b);
    logic [3:0] v;
    drive(d, 1'b1, b);
    sample(d, v);
    chk($sformatf("d%0d ready before %02h", d, b), 32'(v[1]), 32'd1);
  endtask

  // Entered at a negedge with the byte offered; returns at the negedge of cycle L+1.
  task automatic run_frame(input int d, input logic [7:0] b, input bit hold,
                           input logic [7:0] nb, input logic exp_par);
    int cpb, len, slot;
    logic [3:0] v, e;
    logic erd, acc;
    cpb = cpb_of(d);
    len = (9 + PAR + stops_of(d)) * cpb;
    acc = 1'b0;
    @(posedge clock);
    #1;
    if (hold) drive(d, 1'b1, nb);
    else      drive(d, 1'b0, 8'($urandom));
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clock);
      sample(d, v);
      erd = (k == len + 1);
      e = {(k == len + 1) ? 1'b1 : exp_line(b, k, cpb), (k == len), erd, ~erd};
      chk($sformatf("d%0d frame %02h cyc%0d", d, b, k), 32'(v), 32'(e));
      slot = (k - 1) / cpb;
      if (((k - 1) % cpb == 0) && slot >= 1 && slot <= 8) acc = acc ^ v[3];
`ifdef UART_TX_PARITY_EN
      if (k == 9 * cpb + 1) chk($sformatf("d%0d parity bit %02h", d, b), 32'(v[3]), 32'(exp_par));
`endif
      if (!hold) begin
        if (k < len) drive(d, 1'($urandom), 8'($urandom));
        else         drive(d, 1'b0, 8'h00);
      end
    end
    chk($sformatf("d%0d data parity %02h", d, b), 32'(acc), 32'(exp_par));
  endtask

  task automatic idle_check(input int n);
    logic [3:0] v;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        sample(d, v);
        chk($sformatf("d%0d idle", d), 32'(v), 32'(4'b1010));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    logic [7:0] rb;

    vecs[0] = '{8'h24, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h01, 1'b1};
    vecs[6] = '{8'h5A, 1'b0};
    vecs[7] = '{8'hC3, 1'b0};

    reset_n = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    idle_check(20);

    for (int i = 0; i < 8; i++) begin
      offer(0, vecs[i].data);
      run_frame(0, vecs[i].data, 1'b0, 8'h00, vecs[i].exp_par);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Held valid during a frame: second byte goes out on the first idle edge.
    offer(0, 8'h1F);
    run_frame(0, 8'h1F, 1'b1, 8'h4A, 1'b1);
    run_frame(0, 8'h4A, 1'b0, 8'h00, 1'b1);

    // Reset in the middle of data bit 3 of 0xA5.
    offer(0, 8'hA5);
    @(posedge clock);
    #1;
    drive(0, 1'b0, 8'h00);
    repeat (9) @(negedge clock);
    sample(0, v);
    chk("d0 bit3 before reset", 32'(v), 32'(4'b0001));
    reset_n = 1'b0;
    #1;
    sample(0, v);
    chk("d0 async reset", 32'(v), 32'(4'b1010));
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      sample(0, v);
      chk("d0 held in reset", 32'(v), 32'(4'b1010));
    end
    reset_n = 1'b1;
    idle_check(2);
    offer(0, 8'h42);
    run_frame(0, 8'h42, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      offer(0, rb);
      run_frame(0, rb, 1'b0, 8'h00, ^rb);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    offer(1, 8'hFF);
    run_frame(1, 8'hFF, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      offer(1, rb);
      run_frame(1, rb, 1'b0, 8'h00, ^rb);
    end

    offer(2, 8'h24);
    run_frame(2, 8'h24, 1'b1, 8'hA5, 1'b0);
    run_frame(2, 8'hA5, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      offer(2, rb);
      run_frame(2, rb, 1'b0, 8'h00, ^rb);
    end

    idle_check(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
